led_strip_framebuf: RTL and testbench

- APB slave that holds a per-LED 24-bit GRB colour frame buffer and serialises it onto a single-wire WS2812-class LED data line.
- Sits directly upstream of the strip, beside the red/green pattern generator. Firmware writes arbitrary colours here instead of fixed patterns; the two `led_out` lines are muxed at top level.
- Decoded at APB slot `PADDR[11:8] == 8`.

---
 rtl/led_strip_framebuf_if.sv | 22 ++
 rtl/led_strip_framebuf.sv | 209 ++++++++++++++++++++
 tb/tb_led_strip_framebuf.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_strip_framebuf_if.sv
// APB bus bundle for the LED strip frame buffer.
// The master drives the request; the slave returns read data, ready and error.
interface led_strip_framebuf_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/led_strip_framebuf.sv
// APB-mapped 24-bit GRB frame buffer serialised onto a WS2812-class data line.
// Define LED_STRIP_AUTO_REFRESH_EN to enable continuous re-transmission (CTRL.AUTO).
module led_strip_framebuf #(
  parameter int MAX_LEDS     = 16,
  parameter int BIT_PERIOD   = 61,
  parameter int T1H          = 42,
  parameter int T0H          = 19,
  parameter int RESET_PERIOD = 50000
) (
  input  logic                 PCLK,
  input  logic                 PRESERN,
  led_strip_framebuf_if.slave  apb,
  output logic                 led_out,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int IDXW    = (MAX_LEDS > 1) ? $clog2(MAX_LEDS) : 1;
  localparam int CNT_MAX = (RESET_PERIOD > BIT_PERIOD) ? RESET_PERIOD : BIT_PERIOD;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [5:0] OFF_CTRL  = 6'h10;
  localparam logic [5:0] OFF_STAT  = 6'h11;
  localparam logic [5:0] PIX_LIMIT = 6'(MAX_LEDS);
  localparam logic [4:0] LEN_MAX   = 5'(MAX_LEDS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_BIT   = 2'd2;
  localparam logic [1:0] S_LATCH = 2'd3;

  logic [23:0]   r_pixel [MAX_LEDS];
  logic [4:0]    r_len;
  logic [4:0]    r_ledIdx;
  logic [4:0]    r_bitIdx;
  logic [23:0]   r_shift;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_state;
  logic          r_done;
  logic          r_busy;
  logic          r_led;
  logic          r_frameDone;

  logic            w_auto;
  logic            w_sel;
  logic            w_acc;
  logic            w_wr;
  logic [5:0]      w_off;
  logic [IDXW-1:0] w_pixIdx;
  logic            w_isPix;
  logic            w_isCtrl;
  logic            w_isStat;
  logic [4:0]      w_newLen;
  logic            w_pixOpen;
  logic            w_pixErr;
  logic            w_lenErr;
  logic            w_start;
  logic [CW-1:0]   w_curThr;
  logic            w_latchEnd;
  logic [31:0]     w_rdata;
  logic            w_unused;

`ifdef LED_STRIP_AUTO_REFRESH_EN
  logic r_auto;
  assign w_auto = r_auto;
`else
  assign w_auto = 1'b0;
`endif

  assign w_sel    = apb.PSEL & (apb.PADDR[11:8] == 4'h8);
  assign w_acc    = w_sel & apb.PENABLE;
  assign w_wr     = w_acc & apb.PWRITE;
  assign w_off    = apb.PADDR[7:2];
  assign w_pixIdx = w_off[IDXW-1:0];
  assign w_isPix  = (w_off < PIX_LIMIT);
  assign w_isCtrl = (w_off == OFF_CTRL);
  assign w_isStat = (w_off == OFF_STAT);

  assign w_newLen = ((apb.PWDATA[4:0] == 5'd0) || (apb.PWDATA[4:0] > LEN_MAX)) ?
                    LEN_MAX : apb.PWDATA[4:0];

  // In auto-refresh the pixel RAM may be updated only while the line is latching.
  assign w_pixOpen = ~r_busy | (w_auto & (r_state == S_LATCH));
  assign w_pixErr  = w_wr & w_isPix & ~w_pixOpen;
  // Rewriting CTRL with the current LEN (e.g. a START or AUTO change) is not an error.
  assign w_lenErr  = w_wr & w_isCtrl & r_busy & (w_newLen != r_len);
  assign w_start   = w_wr & w_isCtrl & apb.PWDATA[8] & (r_state == S_IDLE);

  assign w_curThr   = r_shift[23] ? CW'(T1H) : CW'(T0H);
  assign w_latchEnd = (r_state == S_LATCH) && (r_cnt == CW'(RESET_PERIOD));

  always_comb begin
    w_rdata = 32'd0;
    if (w_sel) begin
      if (w_isPix) begin
        w_rdata = {8'd0, r_pixel[w_pixIdx]};
      end else if (w_isCtrl) begin
        w_rdata[4:0] = r_len;
        w_rdata[9]   = w_auto;
      end else if (w_isStat) begin
        w_rdata[1:0] = {r_done, r_busy};
      end
    end
  end

  assign apb.PRDATA  = w_rdata;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = w_pixErr | w_lenErr;

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      for (int i = 0; i < MAX_LEDS; i++) r_pixel[i] <= 24'd0;
    end else if (w_wr & w_isPix & w_pixOpen) begin
      r_pixel[w_pixIdx] <= apb.PWDATA[23:0];
    end
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      r_len  <= LEN_MAX;
      r_done <= 1'b0;
    end else begin
      if (w_wr & w_isCtrl & ~r_busy) r_len <= w_newLen;
      r_done <= w_latchEnd | (r_done & ~(w_wr & w_isStat & apb.PWDATA[1]));
    end
  end

`ifdef LED_STRIP_AUTO_REFRESH_EN
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      r_auto <= 1'b0;
    end else if (w_wr & w_isCtrl) begin
      r_auto <= apb.PWDATA[9];
    end
  end
`endif

  // led_out is registered, so the line trails the bit counter by one cycle.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_led       <= 1'b0;
      r_frameDone <= 1'b0;
      r_ledIdx    <= 5'd0;
      r_bitIdx    <= 5'd0;
      r_shift     <= 24'd0;
      r_cnt       <= '0;
    end else begin
      r_frameDone <= 1'b0;
      r_led       <= (r_state == S_BIT) && (r_cnt < w_curThr);
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state  <= S_LOAD;
            r_busy   <= 1'b1;
            r_ledIdx <= 5'd0;
          end
        end
        S_LOAD: begin
          r_shift  <= r_pixel[r_ledIdx[IDXW-1:0]];
          r_bitIdx <= 5'd23;
          r_cnt    <= '0;
          r_state  <= S_BIT;
        end
        S_BIT: begin
          if (r_cnt != CW'(BIT_PERIOD)) begin
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_cnt <= '0;
            if (r_bitIdx != 5'd0) begin
              r_shift  <= {r_shift[22:0], 1'b0};
              r_bitIdx <= r_bitIdx - 5'd1;
            end else if ((r_ledIdx + 5'd1) < r_len) begin
              r_ledIdx <= r_ledIdx + 5'd1;
              r_state  <= S_LOAD;
            end else begin
              r_state <= S_LATCH;
            end
          end
        end
        S_LATCH: begin
          if (!w_latchEnd) begin
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_cnt       <= '0;
            r_ledIdx    <= 5'd0;
            r_frameDone <= 1'b1;
            if (w_auto) begin
              r_state <= S_LOAD;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign led_out    = r_led;
  assign busy       = r_busy;
  assign frame_done = r_frameDone;

  assign w_unused = &{1'b0, apb.PADDR[31:12], apb.PADDR[1:0],
                      apb.PWDATA[31:24], apb.PWDATA[9], r_ledIdx};

endmodule

// File: tb/tb_led_strip_framebuf.sv
// Self-checking bench for led_strip_framebuf: register table, waveform model, busy/reset corners.
// Latch time is shortened via RESET_PERIOD to keep frames short.
module tb_led_strip_framebuf;
  localparam int MAXL = 16;
  localparam int BP   = 62;
  localparam int T1   = 42;
  localparam int T0   = 19;
  localparam int R    = 300;
`ifdef LED_STRIP_AUTO_REFRESH_EN
  localparam logic [31:0] AUTO_BIT = 32'h200;
`else
  localparam logic [31:0] AUTO_BIT = 32'h000;
`endif

  typedef struct {
    logic        wr;
    logic [3:0]  slot;
    logic [5:0]  off;
    logic [31:0] wdata;
    logic [31:0] expRd;
    logic        expErr;
  } vec_t;

  logic PCLK = 1'b0;
  logic PRESERN = 1'b0;
  logic led_out, busy, frame_done;
  int   errors = 0;
  int   checks = 0;
  int   cycCount = 0;
  logic [23:0] modelPix [MAXL];

  led_strip_framebuf_if apb ();

  led_strip_framebuf #(.RESET_PERIOD(R)) dut (
    .PCLK       (PCLK),
    .PRESERN    (PRESERN),
    .apb        (apb),
    .led_out    (led_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cycCount <= cycCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One full APB transfer; read data and error are captured in the access phase.
  task automatic applyStimulus(input logic wr, input logic [3:0] slot, input logic [5:0] off,
                               input logic [31:0] wdata, output logic [31:0] rdata,
                               output logic err);
    @(posedge PCLK); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = wr;
    apb.PADDR = {20'd0, slot, off, 2'b00}; apb.PWDATA = wdata;
    @(posedge PCLK); #1;
    apb.PENABLE = 1'b1;
    #1;
    rdata = apb.PRDATA;
    err   = apb.PSLVERR;
    @(posedge PCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
  endtask

  task automatic regWrite(input logic [5:0] off, input logic [31:0] d, output logic err);
    logic [31:0] rd;
    applyStimulus(1'b1, 4'h8, off, d, rd, err);
  endtask

  task automatic regRead(input logic [5:0] off, output logic [31:0] d);
    logic err;
    applyStimulus(1'b0, 4'h8, off, 32'd0, d, err);
  endtask

  function automatic int frameCycles(input int len);
    return len * 24 * BP + len + R + 1;
  endfunction

  // Called right after the START access edge; compares the line against the pixel model.
  task automatic runFrame(input int len, input string tag);
    bit q[$];
    int kDone, hi;
    int ledErr = 0, busyErr = 0, fdErr = 0;
    logic expLed;
    q.push_back(1'b0);
    for (int i = 0; i < len; i++) begin
      if (i > 0) q.push_back(1'b0);
      for (int b = 23; b >= 0; b--) begin
        hi = modelPix[i][b] ? T1 : T0;
        for (int c = 0; c < BP; c++) q.push_back(c < hi);
      end
    end
    kDone = q.size() + R + 1;
    checkOutput({tag, " busy at start"}, 32'(busy), 32'd1);
    for (int k = 1; k <= kDone + 1; k++) begin
      @(posedge PCLK); #1;
      expLed = (k <= q.size()) ? q[k-1] : 1'b0;
      if (led_out !== expLed) ledErr++;
      if (busy !== (k < kDone)) busyErr++;
      if (frame_done !== (k == kDone)) fdErr++;
    end
    checkOutput({tag, " led_out bad cycles"}, 32'(ledErr), 32'd0);
    checkOutput({tag, " busy bad cycles"}, 32'(busyErr), 32'd0);
    checkOutput({tag, " frame_done bad cycles"}, 32'(fdErr), 32'd0);
  endtask

  initial begin
    vec_t vecs[$];
    logic [31:0] rd, v;
    logic er;
    int len, idx, startCyc, t1, t2, fdCount;

    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    apb.PADDR = 32'd0; apb.PWDATA = 32'd0;
    for (int i = 0; i < MAXL; i++) modelPix[i] = 24'd0;

    repeat (3) @(posedge PCLK);
    #1;
    checkOutput("reset led_out", 32'(led_out), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset frame_done", 32'(frame_done), 32'd0);
    PRESERN = 1'b1;
    checkOutput("PREADY", 32'(apb.PREADY), 32'd1);

    vecs.push_back('{1'b0, 4'h8, 6'h00, 32'h0,        32'h0,              1'b0});
    vecs.push_back('{1'b0, 4'h8, 6'h10, 32'h0,        32'h10,             1'b0});
    vecs.push_back('{1'b0, 4'h8, 6'h11, 32'h0,        32'h0,              1'b0});
    vecs.push_back('{1'b1, 4'h8, 6'h00, 32'hAB123456, 32'h0,              1'b0});
    vecs.push_back('{1'b0, 4'h8, 6'h00, 32'h0,        32'h123456,         1'b0});
    vecs.push_back('{1'b1, 4'h7, 6'h00, 32'hFFFFFF,   32'h0,              1'b0});
    vecs.push_back('{1'b0, 4'h7, 6'h00, 32'h0,        32'h0,              1'b0});
    vecs.push_back('{1'b0, 4'h8, 6'h00, 32'h0,        32'h123456,         1'b0});
    vecs.push_back('{1'b1, 4'h8, 6'h10, 32'h0,        32'h0,              1'b0});
    vecs.push_back('{1'b0, 4'h8, 6'h10, 32'h0,        32'h10,             1'b0});
    vecs.push_back('{1'b1, 4'h8, 6'h10, 32'h14,       32'h0,              1'b0});
    vecs.push_back('{1'b0, 4'h8, 6'h10, 32'h0,        32'h10,             1'b0});
    vecs.push_back('{1'b1, 4'h8, 6'h10, 32'h5,        32'h0,              1'b0});
    vecs.push_back('{1'b0, 4'h8, 6'h10, 32'h0,        32'h5,              1'b0});
    vecs.push_back('{1'b1, 4'h8, 6'h12, 32'hFFFFFFFF, 32'h0,              1'b0});
    vecs.push_back('{1'b0, 4'h8, 6'h12, 32'h0,        32'h0,              1'b0});
    vecs.push_back('{1'b0, 4'h8, 6'h0F, 32'h0,        32'h0,              1'b0});
    vecs.push_back('{1'b1, 4'h8, 6'h0F, 32'hFFFFFFFF, 32'h0,              1'b0});
    vecs.push_back('{1'b0, 4'h8, 6'h0F, 32'h0,        32'hFFFFFF,         1'b0});
    vecs.push_back('{1'b1, 4'h8, 6'h10, 32'h200,      32'h0,              1'b0});
    vecs.push_back('{1'b0, 4'h8, 6'h10, 32'h0,        32'h10 | AUTO_BIT,  1'b0});
    vecs.push_back('{1'b1, 4'h8, 6'h10, 32'h10,       32'h0,              1'b0});
    vecs.push_back('{1'b0, 4'h8, 6'h10, 32'h0,        32'h10,             1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].wr, vecs[i].slot, vecs[i].off, vecs[i].wdata, rd, er);
      if (!vecs[i].wr) checkOutput($sformatf("vec%0d rdata", i), rd, vecs[i].expRd);
      checkOutput($sformatf("vec%0d pslverr", i), 32'(er), 32'(vecs[i].expErr));
    end
    modelPix[0]  = 24'h123456;
    modelPix[15] = 24'hFFFFFF;

    regWrite(6'h00, 32'hFF0000, er); modelPix[0] = 24'hFF0000;
    regWrite(6'h10, 32'h101, er);
    runFrame(1, "frame len1");
    regRead(6'h11, rd);
    checkOutput("status after frame", rd, 32'h2);
    regWrite(6'h11, 32'h2, er);
    regRead(6'h11, rd);
    checkOutput("status done cleared", rd, 32'h0);

    regWrite(6'h01, 32'h000001, er); modelPix[1] = 24'h000001;
    regWrite(6'h10, 32'h102, er);
    runFrame(2, "frame len2");

    for (int f = 0; f < 3; f++) begin
      len = int'($urandom_range(1, 3));
      for (int i = 0; i < len; i++) begin
        v = $urandom;
        regWrite(6'(i), v, er);
        modelPix[i] = v[23:0];
      end
      regWrite(6'h10, 32'h100 | 32'(len), er);
      runFrame(len, $sformatf("random frame%0d", f));
    end

    for (int n = 0; n < 8; n++) begin
      idx = int'($urandom_range(0, MAXL - 1));
      v = $urandom;
      regWrite(6'(idx), v, er);
      modelPix[idx] = v[23:0];
      regRead(6'(idx), rd);
      checkOutput($sformatf("random readback %0d", n), rd, {8'd0, modelPix[idx]});
    end

    regWrite(6'h10, 32'h102, er);
    startCyc = cycCount;
    regWrite(6'h00, 32'h0ABCDE, er);
    checkOutput("busy pixel write err", 32'(er), 32'd1);
    regRead(6'h00, rd);
    checkOutput("busy pixel unchanged", rd, {8'd0, modelPix[0]});
    regWrite(6'h10, 32'h102, er);
    checkOutput("busy restart no err", 32'(er), 32'd0);
    regWrite(6'h10, 32'h101, er);
    checkOutput("busy len write err", 32'(er), 32'd1);
    regRead(6'h10, rd);
    checkOutput("busy len unchanged", rd, 32'h2);
    regWrite(6'h11, 32'h2, er);
    checkOutput("busy status write ok", 32'(er), 32'd0);
    regRead(6'h11, rd);
    checkOutput("busy status value", rd, 32'h1);
    while (frame_done !== 1'b1 && (cycCount - startCyc) < frameCycles(2) + 50) begin
      @(posedge PCLK); #1;
    end
    checkOutput("busy frame length", 32'(cycCount - startCyc), 32'(frameCycles(2)));

    regWrite(6'h00, 32'hFFFFFF, er); modelPix[0] = 24'hFFFFFF;
    regWrite(6'h10, 32'h101, er);
    repeat (5) begin @(posedge PCLK); #1; end
    checkOutput("pre-reset led_out high", 32'(led_out), 32'd1);
    #2 PRESERN = 1'b0;
    #1;
    checkOutput("async reset led_out", 32'(led_out), 32'd0);
    checkOutput("async reset busy", 32'(busy), 32'd0);
    @(posedge PCLK); #1;
    PRESERN = 1'b1;
    for (int i = 0; i < MAXL; i++) modelPix[i] = 24'd0;
    regRead(6'h00, rd);
    checkOutput("post-reset pixel0", rd, 32'h0);
    regRead(6'h01, rd);
    checkOutput("post-reset pixel1", rd, 32'h0);
    regRead(6'h10, rd);
    checkOutput("post-reset ctrl", rd, 32'h10);
    regRead(6'h11, rd);
    checkOutput("post-reset status", rd, 32'h0);

`ifdef LED_STRIP_AUTO_REFRESH_EN
    regWrite(6'h00, 32'h5A5A5A, er);
    regWrite(6'h10, 32'h301, er);
    startCyc = cycCount;
    while (frame_done !== 1'b1 && (cycCount - startCyc) < frameCycles(1) + 50) begin
      @(posedge PCLK); #1;
    end
    checkOutput("auto first frame", 32'(cycCount - startCyc), 32'(frameCycles(1)));
    t1 = cycCount;
    @(posedge PCLK); #1;
    while (frame_done !== 1'b1 && (cycCount - t1) < frameCycles(1) + 50) begin
      @(posedge PCLK); #1;
    end
    t2 = cycCount;
    checkOutput("auto period", 32'(t2 - t1), 32'(24 * BP + 1 + R + 1));
    checkOutput("auto busy held", 32'(busy), 32'd1);
    regWrite(6'h10, 32'h001, er);
    checkOutput("auto clear no err", 32'(er), 32'd0);
    fdCount = 0;
    for (int k = 0; k < 2 * frameCycles(1); k++) begin
      @(posedge PCLK); #1;
      if (frame_done === 1'b1) fdCount++;
    end
    checkOutput("auto tail frames", 32'(fdCount), 32'd1);
    checkOutput("auto idle busy", 32'(busy), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
